// File: rtl/piano_pkg.sv
// Shared definitions for the microphone note detector.
//   state_t   : two-phase FIFO handshake states (WAIT, PROC)
//   NOTE_NONE : empty one-hot note vector
//   BAND_LO/HI: inclusive rising-crossing bounds per window for tones 0..5
package piano_pkg;

  typedef enum logic {
    WAIT,
    PROC
  } state_t;

  localparam int unsigned NUM_TONES = 6;
  localparam logic [5:0]  NOTE_NONE = 6'b0;

  // Index 0 is the rightmost element (tone 0, the highest pitch).
  localparam logic [NUM_TONES-1:0][11:0] BAND_LO =
    {12'd3, 12'd6, 12'd12, 12'd25, 12'd49, 12'd98};
  localparam logic [NUM_TONES-1:0][11:0] BAND_HI =
    {12'd5, 12'd11, 12'd24, 12'd48, 12'd97, 12'd195};

endpackage

// File: rtl/note_band_classifier.sv
// Combinational mapping of a window's crossing and loudness counts to a
// one-hot tone.
//   xing_cnt : rising zero-crossings counted in the window
//   loud_cnt : samples whose magnitude exceeded the loudness threshold
//   result   : one-hot tone (bit i = play_tone bit i), NOTE_NONE if quiet
//              or outside every band
module note_band_classifier
  import piano_pkg::*;
#(
  parameter int unsigned MIN_LOUD = 256
) (
  input  logic [11:0] xing_cnt,
  input  logic [11:0] loud_cnt,
  output logic [5:0]  result
);

  always_comb begin
    result = NOTE_NONE;
    if (loud_cnt >= 12'(MIN_LOUD)) begin
      // Bands are disjoint, so at most one bit is set.
      for (int unsigned i = 0; i < NUM_TONES; i++) begin
        if (xing_cnt >= BAND_LO[3'(i)] && xing_cnt <= BAND_HI[3'(i)]) begin
          result[3'(i)] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mic_note_detector.sv
// Drains microphone samples from the Audio_Controller input FIFO, counts
// hysteresis zero-crossings over fixed windows and reports the dominant
// game tone as a one-hot vector in the user_input format.
//   clock, resetn          : CLOCK_50, asynchronous active-low reset
//   enable                 : classification enable (draining continues)
//   audio_in_available     : FIFO non-empty
//   audio_in_data          : signed sample at FIFO head
//   read_audio_in          : one-clock pop strobe
//   note_out               : confirmed one-hot tone, 0 = none
//   note_valid             : one-clock pulse whenever note_out changes
//   crossings_last         : crossing count of the last completed window
module mic_note_detector
  import piano_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = 32,
  parameter int unsigned WINDOW     = 2048,
  parameter int          HYST       = 4000000,
  parameter int          AMP_THRESH = 20000000,
  parameter int unsigned MIN_LOUD   = 256,
  parameter int unsigned CONFIRM    = 2
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       enable,
  input  logic                       audio_in_available,
  input  logic signed [SAMPLE_W-1:0] audio_in_data,
  output logic                       read_audio_in,
  output logic [5:0]                 note_out,
  output logic                       note_valid,
  output logic [11:0]                crossings_last
);

  localparam int unsigned CONF_W = $clog2(CONFIRM + 1);
  localparam logic [CONF_W-1:0] CONF_MAX = CONF_W'(CONFIRM);
  localparam logic signed [SAMPLE_W-1:0] HYST_S     = SAMPLE_W'(HYST);
  localparam logic signed [SAMPLE_W-1:0] NEG_HYST_S = -HYST_S;
  localparam logic signed [SAMPLE_W-1:0] AMP_S      = SAMPLE_W'(AMP_THRESH);
  localparam logic signed [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic signed [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [11:0] CNT_MAX  = '1;
  localparam logic [11:0] WIN_LAST = 12'(WINDOW - 1);

  state_t                     state, state_next;
  logic signed [SAMPLE_W-1:0] sample_r;
  logic signed [SAMPLE_W-1:0] mag;
  logic                       loud, pos_r, pos_next, rise, win_end;
  logic [11:0]                samp_cnt, xing_cnt, loud_cnt;
  logic [11:0]                xing_inc, loud_inc;
  logic [5:0]                 result, cand;
  logic [CONF_W-1:0]          conf_cnt;

  // Handshake: pop in WAIT, process in PROC, so at most one pop per two clocks.
  always_comb begin
    state_next    = state;
    read_audio_in = 1'b0;
    case (state)
      WAIT: begin
        if (audio_in_available) begin
          read_audio_in = 1'b1;
          state_next    = PROC;
        end
      end
      PROC:    state_next = WAIT;
      default: state_next = WAIT;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= WAIT;
      sample_r <= '0;
    end else begin
      state <= state_next;
      if (read_audio_in) sample_r <= audio_in_data;
    end
  end

  // Per-sample datapath; the most negative value saturates to the maximum.
  always_comb begin
    mag      = (sample_r == S_MIN) ? S_MAX : (sample_r[SAMPLE_W-1] ? -sample_r : sample_r);
    loud     = mag > AMP_S;
    pos_next = pos_r;
    if (sample_r > HYST_S)          pos_next = 1'b1;
    else if (sample_r < NEG_HYST_S) pos_next = 1'b0;
    rise     = pos_next & ~pos_r;
    xing_inc = (rise && xing_cnt != CNT_MAX) ? xing_cnt + 12'd1 : xing_cnt;
    loud_inc = (loud && loud_cnt != CNT_MAX) ? loud_cnt + 12'd1 : loud_cnt;
    win_end  = samp_cnt == WIN_LAST;
  end

  // Classified on the closing sample's counts so it is included in the window.
  note_band_classifier #(
    .MIN_LOUD(MIN_LOUD)
  ) u_classifier (
    .xing_cnt(xing_inc),
    .loud_cnt(loud_inc),
    .result  (result)
  );

  // Sign tracker keeps following the signal across windows and while disabled.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)            pos_r <= 1'b0;
    else if (state == PROC) pos_r <= pos_next;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      samp_cnt       <= '0;
      xing_cnt       <= '0;
      loud_cnt       <= '0;
      cand           <= NOTE_NONE;
      conf_cnt       <= '0;
      crossings_last <= '0;
    end else if (!enable) begin
      samp_cnt <= '0;
      xing_cnt <= '0;
      loud_cnt <= '0;
      cand     <= NOTE_NONE;
      conf_cnt <= '0;
    end else if (state == PROC) begin
      if (win_end) begin
        samp_cnt       <= '0;
        xing_cnt       <= '0;
        loud_cnt       <= '0;
        crossings_last <= xing_inc;
        if (result == cand) begin
          if (conf_cnt != CONF_MAX) conf_cnt <= conf_cnt + 1'b1;
        end else begin
          conf_cnt <= CONF_W'(1);
          cand     <= result;
        end
      end else begin
        samp_cnt <= samp_cnt + 12'd1;
        xing_cnt <= xing_inc;
        loud_cnt <= loud_inc;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      note_out   <= NOTE_NONE;
      note_valid <= 1'b0;
    end else begin
      note_valid <= 1'b0;
      if (!enable) begin
        if (note_out != NOTE_NONE) begin
          note_out   <= NOTE_NONE;
          note_valid <= 1'b1;
        end
      end else if (conf_cnt == CONF_MAX && cand != note_out) begin
        note_out   <= cand;
        note_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mic_note_detector.sv
module tb_mic_note_detector;

  logic               clock = 1'b0;
  logic               resetn;
  logic               enable;
  logic               audio_in_available;
  logic signed [31:0] audio_in_data;
  logic               read_audio_in;
  logic [5:0]         note_out;
  logic               note_valid;
  logic [11:0]        crossings_last;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_note[$];

  mic_note_detector #(
    .SAMPLE_W  (32),
    .WINDOW    (2048),
    .HYST      (4000000),
    .AMP_THRESH(20000000),
    .MIN_LOUD  (256),
    .CONFIRM   (2)
  ) dut (
    .clock             (clock),
    .resetn            (resetn),
    .enable            (enable),
    .audio_in_available(audio_in_available),
    .audio_in_data     (audio_in_data),
    .read_audio_in     (read_audio_in),
    .note_out          (note_out),
    .note_valid        (note_valid),
    .crossings_last    (crossings_last)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every note_valid pulse must match the next expected note.
  always @(negedge clock) begin
    if (resetn === 1'b1 && note_valid === 1'b1) begin
      checks++;
      if (exp_note.size() == 0) begin
        errors++;
        $display("FAIL note_pulse unexpected: note_out=%b required no pulse", note_out);
      end else begin
        logic [5:0] e;
        e = exp_note.pop_front();
        if (note_out !== e) begin
          errors++;
          $display("FAIL note_pulse note_out=%b required=%b", note_out, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Square wave of period p samples, negative half first.
  function automatic logic signed [31:0] sq(input int n, input int p, input int a);
    return ((n % p) < (p / 2)) ? -a : a;
  endfunction

  task automatic push_sample(input logic signed [31:0] s);
    bit got;
    got = 1'b0;
    audio_in_data      = s;
    audio_in_available = 1'b1;
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge clock);
      if (read_audio_in === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL pop_timeout read_audio_in never asserted for sample %0d", s);
    end else begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle(input int n);
    audio_in_available = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic run_window(input string name, input int p, input int a,
                            input int exp_x, input logic [5:0] exp_n);
    for (int n = 0; n < 2048; n++) push_sample(sq(n, p, a));
    idle(3);
    check({name, "_crossings"}, 32'(crossings_last), exp_x);
    check({name, "_note"}, 32'(note_out), 32'(exp_n));
  endtask

  initial begin
    resetn = 1'b0;
    enable = 1'b0;
    audio_in_available = 1'b0;
    audio_in_data = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_note_out", 32'(note_out), 0);
    check("reset_note_valid", 32'(note_valid), 0);
    check("reset_crossings", 32'(crossings_last), 0);
    check("reset_read", 32'(read_audio_in), 0);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Handshake: available held high for 10 cycles gives pops on even cycles.
    begin
      int pops;
      pops = 0;
      audio_in_available = 1'b1;
      for (int i = 0; i < 10; i++) begin
        audio_in_data = 32'(1000 + i);
        @(negedge clock);
        check($sformatf("hs_read_c%0d", i), 32'(read_audio_in), (i % 2 == 0) ? 1 : 0);
        if (read_audio_in === 1'b1) pops++;
        @(posedge clock);
        #1;
        if (i % 2 == 0) check($sformatf("hs_sample_c%0d", i), dut.sample_r, 32'(1000 + i));
      end
      audio_in_available = 1'b0;
      check("hs_pop_count", pops, 5);
    end

    enable = 1'b1;
    idle(1);

    // Quiet 3 kHz tone: crossings counted but too soft to classify.
    run_window("quiet_w0", 16, 10000000, 128, 6'b000000);
    run_window("quiet_w1", 16, 10000000, 128, 6'b000000);

    // 750 Hz tone: tone 2 confirmed after the second window.
    exp_note.push_back(6'b000100);
    run_window("tone_w0", 64, 100000000, 32, 6'b000000);
    run_window("tone_w1", 64, 100000000, 32, 6'b000100);
    run_window("tone_w2", 64, 100000000, 32, 6'b000100);

    // Alternating tone 5 / tone 4 never confirms; steady tone 4 then does.
    exp_note.push_back(6'b010000);
    run_window("alt_w0", 512, 100000000, 4, 6'b000100);
    run_window("alt_w1", 256, 100000000, 8, 6'b000100);
    run_window("alt_w2", 512, 100000000, 4, 6'b000100);
    run_window("steady_w0", 256, 100000000, 8, 6'b000100);
    run_window("steady_w1", 256, 100000000, 8, 6'b010000);

    // Noise inside the hysteresis band produces no crossings.
    run_window("noise", 2, 2000000, 0, 6'b010000);

    // Tone 0 confirmed, then reset mid-window.
    exp_note.push_back(6'b000001);
    run_window("hi_w0", 16, 100000000, 128, 6'b010000);
    run_window("hi_w1", 16, 100000000, 128, 6'b000001);
    for (int n = 0; n < 1000; n++) push_sample(sq(n, 16, 100000000));
    audio_in_available = 1'b0;
    @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    check("async_reset_note_out", 32'(note_out), 0);
    check("async_reset_note_valid", 32'(note_valid), 0);
    check("async_reset_crossings", 32'(crossings_last), 0);
    @(negedge clock);
    resetn = 1'b1;
    idle(1);
    exp_note.push_back(6'b000001);
    run_window("post_rst_w0", 16, 100000000, 128, 6'b000000);
    run_window("post_rst_w1", 16, 100000000, 128, 6'b000001);

    // Disabling forces the note off with one pulse.
    exp_note.push_back(6'b000000);
    enable = 1'b0;
    idle(3);
    check("disable_note_out", 32'(note_out), 0);
    idle(2);
    check("scoreboard_drained", exp_note.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mic_note_detector.md
Name: mic_note_detector

Overview:
- Reader-side companion to the audio-out path. Drains microphone samples from the Audio_Controller input FIFO using the audio_in_available / read_audio_in handshake.
- Measures the dominant pitch per fixed window by counting zero-crossings with hysteresis.
- Classifies the pitch into one of the six game tones (the same octave ladder the square-wave generator emits for play_tone bits 0..5).
- Drives a one-hot note vector in the same format as user_input, so a sung or played note can stand in for a GPIO key.

Parameters:
- SAMPLE_W, 32, width of the signed audio_in sample.
- WINDOW, 2048, samples per measurement window (about 42.7 ms at 48 kHz).
- HYST, 32'd4000000, hysteresis half-band for the sign tracker, in sample units.
- AMP_THRESH, 32'd20000000, magnitude above which a sample counts as loud.
- MIN_LOUD, 256, loud samples required per window for a note to be recognised.
- CONFIRM, 2, consecutive identical window results required before note_out changes.

Ports:
- clock  in  1  system clock (CLOCK_50).
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  classification enable; FIFO draining continues while low.
- audio_in_available  in  1  FIFO holds at least one sample.
- audio_in_data  in  SAMPLE_W  signed sample at FIFO head (left channel).
- read_audio_in  out  1  pop strobe, one clock wide.
- note_out  out  6  one-hot detected tone, bit i equals play_tone bit i; 0 means none.
- note_valid  out  1  one-cycle pulse whenever note_out changes.
- crossings_last  out  12  rising-crossing count of the last completed window (debug/HEX).

Behaviour:
- Reset (async, resetn=0): state WAIT; all counters, sign tracker, candidate and confirm count cleared; all outputs 0.
- Handshake FSM:
  - WAIT: if audio_in_available=1, assert read_audio_in combinationally this cycle, latch audio_in_data into sample_r, go to PROC.
  - PROC: one cycle, read_audio_in=0, process sample_r, return to WAIT. This guarantees at most one pop per two clocks, so a stale available flag never double-pops.
- Per sample, processed in PROC:
  - Magnitude: absolute value with the -2^(SAMPLE_W-1) case saturated. If magnitude > AMP_THRESH, loud_cnt increments, saturating at 4095.
  - Sign tracker pos_r: set when sample > +HYST, cleared when sample < -HYST, otherwise held. A 0->1 transition increments xing_cnt, saturating at 4095.
  - samp_cnt increments. When samp_cnt reaches WINDOW-1, the window closes on this sample, which is included in its counts.
- Window close, same PROC cycle:
  - crossings_last <= xing_cnt (including this sample's contribution).
  - If loud_cnt < MIN_LOUD, result = 0.
  - Otherwise the band table applies (inclusive bounds on xing_cnt): bit0 98..195; bit1 49..97; bit2 25..48; bit3 12..24; bit4 6..11; bit5 3..5. Anything else gives result = 0.
  - If result equals the previous window's result, conf_cnt increments, saturating at CONFIRM. Otherwise conf_cnt <= 1 and cand <= result.
  - When conf_cnt reaches CONFIRM and cand != note_out: note_out <= cand on the next clock, with note_valid=1 for exactly that clock.
  - samp_cnt, xing_cnt and loud_cnt clear. pos_r is kept across windows.
- enable=0:
  - Handshake still pops samples, so the FIFO never overflows.
  - Counters, cand and conf_cnt are held cleared.
  - note_out is forced to 0 on the next clock, and note_valid pulses if it was nonzero.
  - When enable rises, the first window starts with the next popped sample.
- audio_in_available dropping while in PROC: no effect.
- All arithmetic on signed SAMPLE_W values. Counters are 12-bit unsigned.

Decomposition:
- Package piano_pkg holds:
  - the six band bound constants (BAND_LO[i], BAND_HI[i]);
  - NOTE_NONE = 6'b0;
  - FSM state encodings WAIT and PROC.
- One natural sub-module, note_band_classifier: purely combinational, inputs xing_cnt and loud_cnt, output one-hot result.
- Window counting, confirmation logic and the handshake stay in mic_note_detector.

Test Plan:
- Handshake: available held 1 for 10 cycles -> read_audio_in pulses on cycles 0, 2, 4, 6, 8 only (5 pops); each pop's data appears in sample_r.
- Tone 763 Hz at amplitude 1e8, 48 kHz, 3 windows -> crossings_last = 32 or 33; note_out = 6'b000100 after window 2; one note_valid pulse.
- Quiet tone at amplitude 1e7 (below AMP_THRESH), 3052 Hz -> note_out stays 0, no note_valid pulse, crossings_last about 130.
- Alternating results 95 Hz / 191 Hz on each window -> note_out never changes because CONFIRM is never met; then steady 191 Hz for 2 windows -> note_out = 6'b010000.
- Noise of ±HYST/2 around zero -> xing_cnt = 0 (hysteresis holds); crossings_last = 0.
- Reset asserted mid-window with note_out = 6'b000001 -> all outputs 0 asynchronously. After release, a full new WINDOW plus CONFIRM windows is needed before note_out returns to 6'b000001.
